// File: rtl/i2c_burst_master.sv
// i2c_burst_master: open-drain I2C master with burst read/write, 0..2 register-address
// bytes, slave clock stretching and NACK abort; driven by a valid/ready command port.
module i2c_burst_master #(
    parameter int SYS_CLK_FREQ = 50_000_000,
    parameter int SCL_FREQ     = 250_000,
    parameter int LEN_W        = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_rd,
    input  logic [6:0]       cmd_dev_addr,
    input  logic [1:0]       cmd_addr_num,
    input  logic [15:0]      cmd_byte_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [7:0]       wr_data,
    output logic             wr_req,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             done,
    output logic             err_nack,
    output logic             busy,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             scl_oe,
    output logic             sda_oe
);
    localparam int QTR = SYS_CLK_FREQ / (4 * SCL_FREQ);
    localparam int CW  = (QTR > 1) ? $clog2(QTR) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_DEV_W, S_ADDR_H, S_ADDR_L,
        S_WDATA, S_RSTART, S_DEV_R, S_RDATA, S_STOP
    } state_t;

    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_ph;
    logic [3:0]       r_bit;
    logic [7:0]       r_sh, r_rd_data;
    logic             r_ack, r_rd, r_sda_oe, r_rd_valid, r_done, r_err;
    logic [6:0]       r_dev;
    logic [1:0]       r_an, r_scl_s, r_sda_s;
    logic [15:0]      r_addr;
    logic [LEN_W-1:0] r_len, r_bcnt;
    logic             w_hold, w_qend, w_bend, w_bend8, w_tx, w_load, w_txb, w_last, w_sda;
    logic [7:0]       w_byte;

    always_comb begin
        w_hold  = (r_ph == 2'd1) && !r_scl_s[1];
        w_qend  = (r_cnt == CW'(QTR - 1)) && !w_hold;
        w_bend  = w_qend && (r_ph == 2'd3);
        w_bend8 = w_bend && (r_bit == 4'd8);
        w_tx    = (r_state == S_DEV_W) || (r_state == S_ADDR_H) || (r_state == S_ADDR_L) ||
                  (r_state == S_WDATA) || (r_state == S_DEV_R);
        w_load  = w_tx && (r_bit == 4'd0) && (r_ph == 2'd0) && (r_cnt == '0);
        w_last  = (r_bcnt == r_len);
        w_byte  = (r_state == S_DEV_W)  ? {r_dev, 1'b0} :
                  (r_state == S_DEV_R)  ? {r_dev, 1'b1} :
                  (r_state == S_ADDR_H) ? r_addr[15:8]  :
                  (r_state == S_ADDR_L) ? r_addr[7:0]   : wr_data;
        w_txb   = w_load ? w_byte[7] : r_sh[7];
        w_next  = r_state;
        w_sda   = 1'b0;
        case (r_state)
            S_IDLE:   if (cmd_valid) w_next = S_START;
            S_START:  begin
                w_sda = r_ph[1];
                if (w_bend) w_next = (r_rd && r_an == 2'd0) ? S_DEV_R : S_DEV_W;
            end
            S_RSTART: begin
                w_sda = r_ph[1];
                if (w_bend) w_next = S_DEV_R;
            end
            S_DEV_W:  if (w_bend8) w_next = r_ack ? S_STOP : r_an[1] ? S_ADDR_H :
                                            (r_an != 2'd0) ? S_ADDR_L : S_WDATA;
            S_ADDR_H: if (w_bend8) w_next = r_ack ? S_STOP : S_ADDR_L;
            S_ADDR_L: if (w_bend8) w_next = r_ack ? S_STOP : r_rd ? S_RSTART : S_WDATA;
            S_WDATA:  if (w_bend8 && (r_ack || w_last)) w_next = S_STOP;
            S_DEV_R:  if (w_bend8) w_next = r_ack ? S_STOP : S_RDATA;
            S_RDATA:  begin
                w_sda = (r_bit == 4'd8) && !w_last;
                if (w_bend8 && w_last) w_next = S_STOP;
            end
            S_STOP:   begin
                w_sda = (r_ph != 2'd3);
                if (w_bend) w_next = S_IDLE;
            end
            default:  w_next = S_IDLE;
        endcase
        if (w_tx) w_sda = (r_bit != 4'd8) && !w_txb;
    end

    // SCL is driven straight from state so it falls first; SDA follows one cycle later
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_ph       <= '0;
            r_bit      <= '0;
            r_sh       <= '0;
            r_ack      <= 1'b0;
            r_rd       <= 1'b0;
            r_dev      <= '0;
            r_an       <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_bcnt     <= '0;
            r_sda_oe   <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_scl_s    <= 2'b11;
            r_sda_s    <= 2'b11;
        end else begin
            r_state    <= w_next;
            r_scl_s    <= {r_scl_s[0], scl_in};
            r_sda_s    <= {r_sda_s[0], sda_in};
            r_sda_oe   <= w_sda;
            r_done     <= (r_state == S_STOP) && w_bend;
            r_rd_valid <= (r_state == S_RDATA) && (r_bit == 4'd8) && (r_ph == 2'd2) && w_qend;
            if ((r_state == S_RDATA) && (r_bit == 4'd8) && (r_ph == 2'd2) && w_qend)
                r_rd_data <= r_sh;
            if (r_state == S_IDLE) begin
                r_cnt  <= '0;
                r_ph   <= '0;
                r_bit  <= '0;
                r_bcnt <= '0;
                if (cmd_valid) begin
                    r_rd   <= cmd_rd;
                    r_dev  <= cmd_dev_addr;
                    r_an   <= cmd_addr_num;
                    r_addr <= cmd_byte_addr;
                    r_len  <= cmd_len;
                    r_err  <= 1'b0;
                end
            end else begin
                if (!w_hold) r_cnt <= w_qend ? '0 : r_cnt + CW'(1);
                if (w_qend) r_ph <= r_ph + 2'd1;
                if (w_bend) r_bit <= (r_bit == 4'd8 || !(w_tx || r_state == S_RDATA)) ? 4'd0 : r_bit + 4'd1;
                if (w_bend8 && (r_state == S_WDATA || r_state == S_RDATA)) r_bcnt <= r_bcnt + 1'b1;
                if (w_bend8 && w_tx && r_ack) r_err <= 1'b1;
                if (w_tx && (r_bit == 4'd8) && (r_ph == 2'd2) && w_qend) r_ack <= r_sda_s[1];
                if (w_load)
                    r_sh <= w_byte;
                else if (w_bend && w_tx)
                    r_sh <= {r_sh[6:0], 1'b0};
                else if ((r_state == S_RDATA) && (r_bit != 4'd8) && (r_ph == 2'd2) && w_qend)
                    r_sh <= {r_sh[6:0], r_sda_s[1]};
            end
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign wr_req    = w_load && (r_state == S_WDATA);
    assign scl_oe    = (r_ph == 2'd0) && (r_state != S_IDLE) && (r_state != S_START);
    assign sda_oe    = r_sda_oe;
    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign done      = r_done;
    assign err_nack  = r_err;
endmodule

// File: tb/tb_i2c_burst_master.sv
// tb_i2c_burst_master: behavioural I2C slave on pulled-up lines plus bus-event and
// read-data scoreboards for the burst master.
module tb_i2c_burst_master;
    logic       sys_clk = 1'b0, sys_rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_ready, cmd_rd = 1'b0;
    logic [6:0] cmd_dev_addr = '0;
    logic [1:0] cmd_addr_num = '0;
    logic [15:0] cmd_byte_addr = '0;
    logic [3:0] cmd_len = '0;
    logic [7:0] wr_data = '0, rd_data;
    logic       wr_req, rd_valid, done, err_nack, busy, scl_oe, sda_oe;
    logic       s_scl = 1'b0, s_sda = 1'b0;
    wire        scl_l = !(scl_oe || s_scl);
    wire        sda_l = !(sda_oe || s_sda);

    int   total = 0, bad = 0;
    int   exp_q[$], exp_rd[$];
    logic [7:0] wr_q[$], slv_q[$];
    bit   sb_on = 1'b1, pend = 1'b0;
    int   wr_cnt = 0, rdv_cnt = 0;
    int   nack_idx = -1, st_idx = -1;

    i2c_burst_master #(.SYS_CLK_FREQ(4_000_000), .SCL_FREQ(250_000), .LEN_W(4)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rd(cmd_rd), .cmd_dev_addr(cmd_dev_addr), .cmd_addr_num(cmd_addr_num),
        .cmd_byte_addr(cmd_byte_addr), .cmd_len(cmd_len), .wr_data(wr_data), .wr_req(wr_req),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err_nack(err_nack), .busy(busy),
        .scl_in(scl_l), .sda_in(sda_l), .scl_oe(scl_oe), .sda_oe(sda_oe));

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // bus events: 0..255 byte, 256 START, 257 STOP, 512+bit ACK slot value
    task automatic logev(input int v);
        if (sb_on) begin
            if (exp_q.size() == 0) check("bus_extra", v, 32'hFFFF_FFFF);
            else check("bus", v, exp_q.pop_front());
        end
    endtask

    int bitn = -1, bidx = 0, scnt = 0, lowc = 0, lowmax = 0;
    bit rd_mode, tx, tx_end, nack_now, p_scl = 1'b1, p_sda = 1'b1;
    logic [7:0] sh, tb;

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            s_scl = 1'b0; s_sda = 1'b0; bitn = -1; tx = 1'b0; scnt = 0;
            p_scl = scl_l; p_sda = sda_l;
        end else begin
            if (scnt > 0) begin
                scnt--;
                if (scnt == 0) s_scl = 1'b0;
            end
            lowc = scl_l ? 0 : lowc + 1;
            if (lowc > lowmax) lowmax = lowc;
            if (p_scl && scl_l && p_sda && !sda_l) begin
                logev(256);
                bitn = -1; bidx = 0; rd_mode = 1'b0; tx = 1'b0; tx_end = 1'b0; s_sda = 1'b0;
            end else if (p_scl && scl_l && !p_sda && sda_l) begin
                logev(257);
                bitn = -1; tx = 1'b0; s_sda = 1'b0;
            end else if (!p_scl && scl_l) begin
                if (bitn >= 0 && bitn < 8) begin
                    sh = {sh[6:0], sda_l};
                    if (bitn == 7) begin
                        logev(int'(sh));
                        nack_now = (bidx == nack_idx);
                        if (bidx == 0) rd_mode = sh[0];
                        bidx++;
                    end
                end else if (bitn == 8) begin
                    logev(512 + int'(sda_l));
                    if (tx && sda_l) tx_end = 1'b1;
                end
            end else if (p_scl && !scl_l) begin
                if (bitn == 8) begin
                    bitn = 0; s_sda = 1'b0; tx = 1'b0;
                    if (rd_mode && !tx_end) begin
                        tx = 1'b1;
                        tb = slv_q.size() ? slv_q.pop_front() : 8'hEE;
                        s_sda = ~tb[7];
                    end
                end else begin
                    bitn++;
                    if (bitn == 8) s_sda = !tx && !nack_now;
                    else if (tx) s_sda = ~tb[7-bitn];
                end
                if (bidx == st_idx && bitn == 3) begin
                    s_scl = 1'b1; scnt = 500;
                end
            end
            p_scl = scl_l; p_sda = sda_l;
        end
    end

    always @(negedge sys_clk) begin
        if (pend && wr_q.size()) void'(wr_q.pop_front());
        pend = wr_req;
        if (wr_req) wr_cnt++;
        wr_data = wr_q.size() ? wr_q[0] : 8'h00;
        if (rd_valid) begin
            rdv_cnt++;
            if (sb_on) begin
                if (exp_rd.size() == 0) check("rd_extra", rd_data, 32'hFFFF_FFFF);
                else check("rd", rd_data, exp_rd.pop_front());
            end
        end
    end

    task automatic evb(input int b, input int a);
        exp_q.push_back(b);
        exp_q.push_back(512 + a);
    endtask

    task automatic issue(input bit rd, input int dev, input int an, input int addr, input int len);
        for (int i = 0; i < 2000 && !cmd_ready; i++) @(negedge sys_clk);
        check("ready_before", cmd_ready, 1);
        cmd_rd = rd; cmd_dev_addr = 7'(dev); cmd_addr_num = 2'(an);
        cmd_byte_addr = 16'(addr); cmd_len = 4'(len); cmd_valid = 1'b1;
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        cmd_rd = ~rd; cmd_dev_addr = ~cmd_dev_addr; cmd_addr_num = ~cmd_addr_num;
        cmd_byte_addr = ~cmd_byte_addr; cmd_len = ~cmd_len;
        check("busy_on", busy, 1);
        check("ready_busy", cmd_ready, 0);
        check("err_clr", err_nack, 0);
    endtask

    task automatic finish_cmd(input int exp_err, input int exp_wr, input int wr0);
        bit seen = 1'b0;
        for (int i = 0; i < 30000 && !seen; i++) begin
            @(negedge sys_clk);
            seen = done;
        end
        check("done_seen", seen, 1);
        check("err_nack", err_nack, exp_err);
        check("busy_off", busy, 0);
        check("bus_left", exp_q.size(), 0);
        check("rd_left", exp_rd.size(), 0);
        check("wr_req_cnt", wr_cnt - wr0, exp_wr);
    endtask

    initial begin
        int w0;
        bit found;
        repeat (3) @(negedge sys_clk);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_scl", scl_oe, 0);
        check("rst_sda", sda_oe, 0);
        check("rst_done", done, 0);
        check("rst_rd_data", rd_data, 0);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);

        // burst write with 2-byte register address
        w0 = wr_cnt;
        wr_q = '{8'hA5, 8'h5A, 8'hFF};
        exp_q.push_back(256);
        evb(8'hA0, 0); evb(8'h12, 0); evb(8'h34, 0); evb(8'hA5, 0); evb(8'h5A, 0); evb(8'hFF, 0);
        exp_q.push_back(257);
        issue(0, 7'h50, 2, 16'h1234, 2);
        finish_cmd(0, 3, w0);

        // burst read with 1-byte register address and repeated START
        w0 = wr_cnt;
        slv_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_rd = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_q.push_back(256); evb(8'h78, 0); evb(8'h0A, 0);
        exp_q.push_back(256); evb(8'h79, 0);
        evb(8'h11, 0); evb(8'h22, 0); evb(8'h33, 0); evb(8'h44, 1);
        exp_q.push_back(257);
        issue(1, 7'h3C, 1, 16'hBB0A, 3);
        finish_cmd(0, 0, w0);
        check("rd_data_last", rd_data, 8'h44);

        // slave NACKs the second register-address byte
        w0 = wr_cnt;
        nack_idx = 2;
        exp_q.push_back(256); evb(8'hA0, 0); evb(8'h12, 0); evb(8'h34, 1);
        exp_q.push_back(257);
        issue(0, 7'h50, 2, 16'h1234, 0);
        finish_cmd(1, 0, w0);
        nack_idx = -1;
        repeat (5) @(negedge sys_clk);
        check("err_hold", err_nack, 1);
        check("rd_hold", rd_data, 8'h44);

        // clock stretching by the slave in bit 3 of the address byte
        w0 = wr_cnt;
        st_idx = 1;
        wr_q = '{8'hC3};
        exp_q.push_back(256); evb(8'h42, 0); evb(8'h55, 0); evb(8'hC3, 0);
        exp_q.push_back(257);
        issue(0, 7'h21, 1, 16'h0055, 0);
        finish_cmd(0, 1, w0);
        st_idx = -1;
        check("stretch_len", lowmax >= 500, 1);

        // reset in the middle of a read burst
        sb_on = 1'b0;
        slv_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        w0 = rdv_cnt;
        issue(1, 7'h3C, 0, 0, 3);
        found = 1'b0;
        for (int i = 0; i < 5000 && !found; i++) begin
            @(negedge sys_clk);
            found = (rdv_cnt > w0);
        end
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge sys_clk);
            found = scl_oe;
        end
        check("pre_rst_scl", scl_oe, 1);
        #1 sys_rst_n = 1'b0;
        #1;
        check("mid_rst_scl", scl_oe, 0);
        check("mid_rst_sda", sda_oe, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", cmd_ready, 1);
        check("mid_rst_rd_data", rd_data, 0);
        repeat (3) @(negedge sys_clk);
        exp_q.delete(); exp_rd.delete(); slv_q.delete(); wr_q.delete();
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        sb_on = 1'b1;

        // current-address single-byte read; commands while busy are ignored
        w0 = wr_cnt;
        slv_q = '{8'h96};
        exp_rd = '{8'h96};
        exp_q.push_back(256); evb(8'h79, 0); evb(8'h96, 1);
        exp_q.push_back(257);
        issue(1, 7'h3C, 0, 16'h0000, 0);
        cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            if (i == 0 || i == 19) check("ready_ignored", cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        finish_cmd(0, 0, w0);
        check("rd_data_single", rd_data, 8'h96);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
